// File: rtl/bp_gshare_pkg.sv
// Shared branch-prediction definitions: PHT hash encodings and the index hash.
package bp_gshare_pkg;

    localparam int unsigned HASH_CONCAT = 0;
    localparam int unsigned HASH_XOR    = 1;
    localparam int unsigned HASH_W      = 32;

    // Wide hash; callers zero-extend pc/ghr and truncate the result to PHT_DEPTH.
    function automatic logic [HASH_W-1:0] bp_hash(
        input logic [HASH_W-1:0] pc,
        input logic [HASH_W-1:0] ghr,
        input int unsigned       mode,
        input int unsigned       ghr_w
    );
        if (mode == HASH_CONCAT) begin
            return (pc << ghr_w) | ghr;
        end
        return pc ^ ghr;
    endfunction

endpackage

// File: rtl/bp_gshare_if.sv
// Pipeline-facing signal bundle of the gshare predictor.
interface bp_gshare_if #(
    parameter int unsigned PC_WIDTH  = 10,
    parameter int unsigned PHT_DEPTH = 10
);
    logic [PC_WIDTH-1:0]  hashed_pcF;
    logic [PC_WIDTH-1:0]  hashed_pcM;
    logic                 branchD;
    logic                 pcsrcPD;
    logic                 branchM;
    logic                 pcsrcM;
    logic                 pcsrcPM;
    logic                 stallE;
    logic                 stallM;
    logic                 flushE;
    logic                 flushM;
    logic                 pcsrcPF;
    logic [PHT_DEPTH-1:0] PHT_indexF;
    logic [PHT_DEPTH-1:0] PHT_indexM;
    logic                 mispredictM;
    logic [31:0]          br_cnt;
    logic [31:0]          mis_cnt;

    modport master (
        output hashed_pcF, hashed_pcM, branchD, pcsrcPD, branchM, pcsrcM, pcsrcPM,
               stallE, stallM, flushE, flushM,
        input  pcsrcPF, PHT_indexF, PHT_indexM, mispredictM, br_cnt, mis_cnt
    );

    modport slave (
        input  hashed_pcF, hashed_pcM, branchD, pcsrcPD, branchM, pcsrcM, pcsrcPM,
               stallE, stallM, flushE, flushM,
        output pcsrcPF, PHT_indexF, PHT_indexM, mispredictM, br_cnt, mis_cnt
    );
endinterface

// File: rtl/bp_sat_counter.sv
// Next-state logic of an up/down saturating counter.
module bp_sat_counter #(
    parameter int unsigned CNT_WIDTH = 2
) (
    input  logic [CNT_WIDTH-1:0] cnt_i,
    input  logic                 inc_i,
    output logic [CNT_WIDTH-1:0] cnt_nxt_c_o
);

    always_comb begin
        cnt_nxt_c_o = cnt_i;
        if (inc_i) begin
            if (cnt_i != '1) cnt_nxt_c_o = cnt_i + CNT_WIDTH'(1);
        end else begin
            if (cnt_i != '0) cnt_nxt_c_o = cnt_i - CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/bp_gshare.sv
// Gshare direction predictor: register-array PHT indexed by pc hashed with
// speculative global history, with D/E/M history checkpoints for recovery.
module bp_gshare
    import bp_gshare_pkg::*;
#(
    parameter int unsigned PHT_DEPTH = 10,
    parameter int unsigned GHR_WIDTH = 8,
    parameter int unsigned HASH_MODE = 1,
    parameter int unsigned PC_WIDTH  = 10,
    parameter int unsigned CNT_WIDTH = 2,
    parameter int unsigned CNT_INIT  = 1
) (
    input logic       clk,
    input logic       rst,
    bp_gshare_if.slave bus
);

    localparam int unsigned          PHT_ENTRIES = 2 ** PHT_DEPTH;
    localparam logic [CNT_WIDTH-1:0] CNT_RST     = CNT_WIDTH'(CNT_INIT);

    logic [PC_WIDTH-1:0]  pc_f;
    logic [PC_WIDTH-1:0]  pc_m;
    logic [GHR_WIDTH-1:0] ghr_q, ghr_d;
    logic [GHR_WIDTH-1:0] ghr_e_q, ghr_e_d;
    logic [GHR_WIDTH-1:0] ghr_m_q, ghr_m_d;
    logic [31:0]          br_cnt_q, br_cnt_d;
    logic [31:0]          mis_cnt_q, mis_cnt_d;
    logic [PHT_DEPTH-1:0] idx_f;
    logic [PHT_DEPTH-1:0] idx_m;
    logic [CNT_WIDTH-1:0] pht [PHT_ENTRIES];
    logic [CNT_WIDTH-1:0] cnt_upd;
    logic                 mispredict;

    assign pc_f  = bus.hashed_pcF;
    assign pc_m  = bus.hashed_pcM;
    assign idx_f = PHT_DEPTH'(bp_hash(HASH_W'(pc_f), HASH_W'(ghr_q), HASH_MODE, GHR_WIDTH));
    assign idx_m = PHT_DEPTH'(bp_hash(HASH_W'(pc_m), HASH_W'(ghr_m_q), HASH_MODE, GHR_WIDTH));

    assign mispredict = bus.branchM & (bus.pcsrcPM ^ bus.pcsrcM);

    assign bus.PHT_indexF  = idx_f;
    assign bus.PHT_indexM  = idx_m;
    assign bus.pcsrcPF     = pht[idx_f][CNT_WIDTH-1];
    assign bus.mispredictM = mispredict;
    assign bus.br_cnt      = br_cnt_q;
    assign bus.mis_cnt     = mis_cnt_q;

    bp_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_sat (
        .cnt_i       (pht[idx_m]),
        .inc_i       (bus.pcsrcM),
        .cnt_nxt_c_o (cnt_upd)
    );

    // History, checkpoints and statistics; recovery beats the decode-time shift.
    always_comb begin
        ghr_d     = ghr_q;
        ghr_e_d   = ghr_e_q;
        ghr_m_d   = ghr_m_q;
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;

        if (mispredict) begin
            ghr_d = {ghr_m_q[GHR_WIDTH-2:0], bus.pcsrcM};
        end else if (bus.branchD) begin
            ghr_d = {ghr_q[GHR_WIDTH-2:0], bus.pcsrcPD};
        end

        // The D checkpoint is the pre-shift GHR, captured straight into E.
        if (bus.flushE)       ghr_e_d = '0;
        else if (!bus.stallE) ghr_e_d = ghr_q;

        if (bus.flushM)       ghr_m_d = '0;
        else if (!bus.stallM) ghr_m_d = ghr_e_q;

        if (bus.branchM && (br_cnt_q != '1)) br_cnt_d  = br_cnt_q + 32'd1;
        if (mispredict && (mis_cnt_q != '1)) mis_cnt_d = mis_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q     <= '0;
            ghr_e_q   <= '0;
            ghr_m_q   <= '0;
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            ghr_q     <= ghr_d;
            ghr_e_q   <= ghr_e_d;
            ghr_m_q   <= ghr_m_d;
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    // One register per PHT entry; same-cycle reads see the pre-update value.
    for (genvar g = 0; g < PHT_ENTRIES; g++) begin : g_pht
        logic [CNT_WIDTH-1:0] cnt_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= CNT_RST;
            end else if (bus.branchM && (idx_m == PHT_DEPTH'(g))) begin
                cnt_q <= cnt_upd;
            end
        end

        assign pht[g] = cnt_q;
    end

endmodule

// File: tb/tb_bp_gshare.sv
// Directed self-checking bench for bp_gshare: xor, concat and wide-counter builds.
module tb_bp_gshare;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    bp_gshare_if #(.PC_WIDTH(10), .PHT_DEPTH(10)) a_if ();
    bp_gshare_if #(.PC_WIDTH(4),  .PHT_DEPTH(8))  c_if ();
    bp_gshare_if #(.PC_WIDTH(10), .PHT_DEPTH(10)) w_if ();

    bp_gshare u_xor (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    bp_gshare #(.PHT_DEPTH(8), .GHR_WIDTH(4), .HASH_MODE(0), .PC_WIDTH(4)) u_cat (
        .clk (clk),
        .rst (rst),
        .bus (c_if)
    );

    bp_gshare #(.CNT_WIDTH(3), .CNT_INIT(4)) u_wide (
        .clk (clk),
        .rst (rst),
        .bus (w_if)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        a_if.hashed_pcF = '0; a_if.hashed_pcM = '0; a_if.branchD = 1'b0; a_if.pcsrcPD = 1'b0;
        a_if.branchM = 1'b0; a_if.pcsrcM = 1'b0; a_if.pcsrcPM = 1'b0;
        a_if.stallE = 1'b0; a_if.stallM = 1'b0; a_if.flushE = 1'b0; a_if.flushM = 1'b0;
        c_if.hashed_pcF = '0; c_if.hashed_pcM = '0; c_if.branchD = 1'b0; c_if.pcsrcPD = 1'b0;
        c_if.branchM = 1'b0; c_if.pcsrcM = 1'b0; c_if.pcsrcPM = 1'b0;
        c_if.stallE = 1'b0; c_if.stallM = 1'b0; c_if.flushE = 1'b0; c_if.flushM = 1'b0;
        w_if.hashed_pcF = '0; w_if.hashed_pcM = '0; w_if.branchD = 1'b0; w_if.pcsrcPD = 1'b0;
        w_if.branchM = 1'b0; w_if.pcsrcM = 1'b0; w_if.pcsrcPM = 1'b0;
        w_if.stallE = 1'b0; w_if.stallM = 1'b0; w_if.flushE = 1'b0; w_if.flushM = 1'b0;
    endtask

    // Same decode-stage branch into both the xor and concat predictors.
    task automatic hist(input logic pd);
        a_if.branchD = 1'b1; a_if.pcsrcPD = pd;
        c_if.branchD = 1'b1; c_if.pcsrcPD = pd;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset defaults
        a_if.hashed_pcF = 10'h155;
        #1;
        chk("rst_pcsrcPF", 32'(a_if.pcsrcPF), 32'd0);
        chk("rst_idxF", 32'(a_if.PHT_indexF), 32'h155);
        chk("rst_br_cnt", a_if.br_cnt, 32'd0);
        chk("rst_mis_cnt", a_if.mis_cnt, 32'd0);

        // Training entry 0x055 (init 1): taken x4 then not-taken x2
        a_if.hashed_pcF = 10'h055; a_if.hashed_pcM = 10'h055;
        a_if.branchM = 1'b1; a_if.pcsrcM = 1'b1; a_if.pcsrcPM = 1'b1;
        #1;
        chk("train_no_bypass", 32'(a_if.pcsrcPF), 32'd0);
        chk("train_no_mispred", 32'(a_if.mispredictM), 32'd0);
        chk("train_idxM", 32'(a_if.PHT_indexM), 32'h055);
        tick();
        chk("train_cnt2", 32'(a_if.pcsrcPF), 32'd1);
        tick();
        tick();
        tick();
        chk("train_sat_pf", 32'(a_if.pcsrcPF), 32'd1);
        a_if.pcsrcM = 1'b0; a_if.pcsrcPM = 1'b0;
        tick();
        chk("train_dec_to2", 32'(a_if.pcsrcPF), 32'd1);
        tick();
        chk("train_dec_to1", 32'(a_if.pcsrcPF), 32'd0);
        a_if.branchM = 1'b0;
        chk("train_br_cnt", a_if.br_cnt, 32'd6);
        chk("train_mis_cnt", a_if.mis_cnt, 32'd0);

        // 3-bit counters from 4: five not-taken reach 0, then climb back
        w_if.hashed_pcF = 10'h011; w_if.hashed_pcM = 10'h011;
        w_if.branchM = 1'b1; w_if.pcsrcM = 1'b0; w_if.pcsrcPM = 1'b0;
        #1;
        chk("wide_init_pf", 32'(w_if.pcsrcPF), 32'd1);
        tick();
        chk("wide_first_dec", 32'(w_if.pcsrcPF), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        w_if.pcsrcM = 1'b1; w_if.pcsrcPM = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("wide_floor_3up", 32'(w_if.pcsrcPF), 32'd0);
        tick();
        chk("wide_floor_4up", 32'(w_if.pcsrcPF), 32'd1);
        w_if.branchM = 1'b0;
        chk("wide_br_cnt", w_if.br_cnt, 32'd9);

        // Speculative history 1,0,1
        a_if.hashed_pcF = '0; a_if.hashed_pcM = '0;
        c_if.hashed_pcF = 4'h3; c_if.hashed_pcM = '0;
        hist(1'b1);
        hist(1'b0);
        hist(1'b1);
        a_if.branchD = 1'b0; c_if.branchD = 1'b0;
        chk("hist_xor_idxF", 32'(a_if.PHT_indexF), 32'h005);
        chk("hist_cat_idxF", 32'(c_if.PHT_indexF), 32'h35);
        chk("hist_xor_idxM", 32'(a_if.PHT_indexM), 32'h001);
        chk("hist_cat_idxM", 32'(c_if.PHT_indexM), 32'h01);

        // E held for two cycles keeps the older checkpoint
        a_if.stallE = 1'b1;
        tick();
        tick();
        a_if.stallE = 1'b0;
        chk("stallE_hold", 32'(a_if.PHT_indexM), 32'h002);
        tick();
        tick();
        chk("ckpt_M_5", 32'(a_if.PHT_indexM), 32'h005);

        // Recovery with a concurrent decode branch
        a_if.branchM = 1'b1; a_if.pcsrcPM = 1'b1; a_if.pcsrcM = 1'b0;
        a_if.branchD = 1'b1; a_if.pcsrcPD = 1'b1;
        #1;
        chk("rec_mispredictM", 32'(a_if.mispredictM), 32'd1);
        tick();
        a_if.branchM = 1'b0; a_if.branchD = 1'b0;
        chk("rec_ghr", 32'(a_if.PHT_indexF), 32'h00A);
        chk("rec_mis_cnt", a_if.mis_cnt, 32'd1);
        chk("rec_br_cnt", a_if.br_cnt, 32'd7);

        // flushM clears the M checkpoint only
        a_if.hashed_pcM = 10'h02A; a_if.flushM = 1'b1;
        tick();
        a_if.flushM = 1'b0;
        chk("flushM_idxM", 32'(a_if.PHT_indexM), 32'h02A);
        chk("flushM_idxF", 32'(a_if.PHT_indexF), 32'h00A);

        // flushE overrides stallE
        a_if.hashed_pcM = '0; a_if.flushE = 1'b1; a_if.stallE = 1'b1;
        tick();
        a_if.flushE = 1'b0; a_if.stallE = 1'b0;
        chk("flushE_prevM", 32'(a_if.PHT_indexM), 32'h00A);
        tick();
        chk("flushE_over_stall", 32'(a_if.PHT_indexM), 32'h000);

        // Reset during recovery wins
        a_if.branchM = 1'b1; a_if.pcsrcPM = 1'b1; a_if.pcsrcM = 1'b0;
        a_if.branchD = 1'b1; a_if.pcsrcPD = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clr();
        a_if.hashed_pcF = 10'h055;
        #1;
        chk("rst2_idxF", 32'(a_if.PHT_indexF), 32'h055);
        chk("rst2_pcsrcPF", 32'(a_if.pcsrcPF), 32'd0);
        chk("rst2_br_cnt", a_if.br_cnt, 32'd0);
        chk("rst2_mis_cnt", a_if.mis_cnt, 32'd0);
        chk("rst2_wide_cnt", w_if.br_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bp_gshare.md
BP_GSHARE -- requirements
Module: bp_gshare

Interface
REQ-001 SHALL have parameter PHT_DEPTH, default 10, log2 of PHT entry count.
REQ-002 SHALL have parameter GHR_WIDTH, default 8, global history bits; 2 <= GHR_WIDTH <= PHT_DEPTH.
REQ-003 SHALL have parameter HASH_MODE, default 1; 0 = concat {pc, GHR}, 1 = xor pc ^ zero-extended GHR.
REQ-004 SHALL have parameter PC_WIDTH, default 10; must equal PHT_DEPTH-GHR_WIDTH in concat mode, PHT_DEPTH in xor mode.
REQ-005 SHALL have parameter CNT_WIDTH, default 2, saturating counter width (>=1).
REQ-006 SHALL have parameter CNT_INIT, default 1, PHT reset value (< 2^CNT_WIDTH).
REQ-007 SHALL have ports:
 clk  in  1  clock, all state on rising edge
 rst  in  1  synchronous active-high reset
 hashed_pcF  in  PC_WIDTH  fetch-stage hashed PC
 hashed_pcM  in  PC_WIDTH  memory-stage hashed PC of resolving branch
 branchD  in  1  decode holds a branch
 pcsrcPD  in  1  prediction carried with the decode branch
 branchM  in  1  memory holds a resolving branch
 pcsrcM  in  1  actual direction
 pcsrcPM  in  1  predicted direction carried to M
 stallE, stallM  in  1  hold E/M checkpoint registers
 flushE, flushM  in  1  invalidate E/M checkpoint registers
 pcsrcPF  out  1  fetch prediction
 PHT_indexF, PHT_indexM  out  PHT_DEPTH  PHT indices
 mispredictM  out  1  branchM & (pcsrcPM ^ pcsrcM)
 br_cnt, mis_cnt  out  32  branch / mispredict counts

Function
REQ-008 PHT_indexF SHALL be hash(hashed_pcF, GHR) per HASH_MODE, combinational.
REQ-009 pcsrcPF SHALL be MSB of PHT[PHT_indexF], combinational, zero added latency.
REQ-010 On branchD, speculative GHR SHALL shift left inserting pcsrcPD; pre-shift GHR SHALL be captured as checkpoint GHR_D.
REQ-011 Checkpoint SHALL advance D->E->M each cycle unless that stage stalls (hold); flushE/flushM SHALL zero the stage register, flush overriding stall.
REQ-012 PHT_indexM SHALL be hash(hashed_pcM, GHR_M), GHR_M being the M-stage checkpoint.
REQ-013 On branchM, PHT[PHT_indexM] SHALL increment if pcsrcM=1 saturating at 2^CNT_WIDTH-1, else decrement saturating at 0; updated next edge.
REQ-014 On mispredictM, GHR SHALL become {GHR_M[GHR_WIDTH-2:0], pcsrcM}, overriding any branchD shift in the same cycle.
REQ-015 Read of an entry written in the same cycle SHALL return the old value (no bypass).
REQ-016 br_cnt SHALL increment on branchM; mis_cnt on mispredictM; both saturate at 2^32-1.
REQ-017 GHR shifting SHALL discard the MSB; no width growth.

Reset
REQ-018 rst SHALL set GHR, all checkpoints, br_cnt, mis_cnt to 0 and every PHT entry to CNT_INIT in one cycle.
REQ-019 During rst: branchD/branchM ignored; outputs reflect reset state next cycle (pcsrcPF = MSB of CNT_INIT).
REQ-020 rst mid-recovery SHALL win over every update.

Structure
REQ-021 HASH_MODE encodings and the hash function SHALL live in the shared branch-prediction package.
REQ-022 Saturating counter next-state SHALL be sub-module bp_sat_counter, parametrised by CNT_WIDTH.
REQ-023 PHT SHALL be a flat register array, no SRAM macro.

Verification
REQ-024 Reset, defaults: any hashed_pcF -> pcsrcPF=0, PHT_indexF=hashed_pcF, counters 0.
REQ-025 Train: 3 branchM taken at pc 0x055, GHR_M=0 -> entry 0x055 = 3; fourth taken stays 3; pcsrcPF=1 when pcF=0x055, GHR=0.
REQ-026 History: branchD with pcsrcPD 1,0,1 from GHR=0 -> GHR=0x05; concat mode GHR_WIDTH=4, pc=0x3 -> PHT_indexF=0x35.
REQ-027 Recovery: GHR_M=0x05, pcsrcPM=1, pcsrcM=0, branchD same cycle -> mispredictM=1, GHR=0x0A, mis_cnt=1.
REQ-028 Flush/stall: stallE held 2 cycles keeps GHR_E; flushM -> GHR_M=0, no PHT index corruption.
REQ-029 CNT_WIDTH=3, CNT_INIT=4: 5 not-taken -> entry 0; pcsrcPF 1 then 0 after first update.
